// File: rtl/pkt_store_fwd_fifo.sv
// Store-and-forward packet FIFO: whole packets are buffered and committed, then an
// external decision forwards or discards each packet in arrival order.
module pkt_store_fwd_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int DESC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              act_valid,
    input  logic              act_drop,
    output logic              act_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic [DESC_W:0]   pkt_count,
    output logic [15:0]       ovf_cnt,
    output logic [15:0]       drop_cnt
);
    localparam int DEPTH    = 2**ADDR_W;
    localparam int MAX_PKTS = 2**DESC_W;

    typedef logic [ADDR_W:0] ptr_t;
    typedef logic [DESC_W:0] dptr_t;
    typedef enum logic [1:0] {IDLE, WAIT_ACT, SEND, DISCARD} state_t;

    logic [DATA_W-1:0] buf_mem  [DEPTH];
    ptr_t              desc_mem [MAX_PKTS];

    state_t            state_q, state_d;
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    ptr_t              commit_ptr_q, commit_ptr_d;
    dptr_t             desc_wr_q, desc_wr_d;
    dptr_t             desc_rd_q, desc_rd_d;
    logic              ovf_drop_q, ovf_drop_d;
    logic [15:0]       ovf_cnt_q, ovf_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    ptr_t              occupancy;
    dptr_t             desc_used;
    logic              buf_full, desc_full;
    logic              buf_we, desc_push;
    ptr_t              desc_end;
    logic [DATA_W-1:0] head_data;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Occupancy counts in-flight beats too, so an uncommitted packet still reserves space.
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign desc_used = desc_wr_q - desc_rd_q;
    assign buf_full  = (occupancy == ptr_t'(DEPTH));
    assign desc_full = (desc_used == dptr_t'(MAX_PKTS));
    assign desc_end  = desc_mem[desc_rd_q[DESC_W-1:0]];
    assign head_data = buf_mem[rd_ptr_q[ADDR_W-1:0]];

    assign pkt_count = desc_used;
    assign ovf_cnt   = ovf_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

    // Write side: accept, commit, or discard the in-flight packet on overflow.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        desc_wr_d    = desc_wr_q;
        ovf_drop_d   = ovf_drop_q;
        ovf_cnt_d    = ovf_cnt_q;
        buf_we       = 1'b0;
        desc_push    = 1'b0;
        if (wr_valid) begin
            if (ovf_drop_q) begin
                if (wr_last) begin
                    ovf_drop_d = 1'b0;
                    ovf_cnt_d  = sat_inc(ovf_cnt_q);
                end
            end else if (buf_full || (wr_last && desc_full)) begin
                wr_ptr_d = commit_ptr_q;
                if (wr_last) ovf_cnt_d = sat_inc(ovf_cnt_q);
                else         ovf_drop_d = 1'b1;
            end else begin
                buf_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
                if (wr_last) begin
                    commit_ptr_d = wr_ptr_q + ptr_t'(1);
                    desc_push    = 1'b1;
                    desc_wr_d    = desc_wr_q + dptr_t'(1);
                end
            end
        end
    end

    // Read side: output FSM. The output beat is registered, so its buffer slot is freed on load.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        desc_rd_d  = desc_rd_q;
        drop_cnt_d = drop_cnt_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        act_ready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (desc_used != '0) state_d = WAIT_ACT;
            end
            WAIT_ACT: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    if (act_drop) begin
                        state_d = DISCARD;
                    end else begin
                        state_d    = SEND;
                        rd_valid_d = 1'b1;
                        rd_data_d  = head_data;
                        rd_last_d  = (rd_ptr_q == desc_end);
                        rd_ptr_d   = rd_ptr_q + ptr_t'(1);
                    end
                end
            end
            SEND: begin
                if (rd_valid_q && rd_ready) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        desc_rd_d  = desc_rd_q + dptr_t'(1);
                        state_d    = IDLE;
                    end else begin
                        rd_data_d = head_data;
                        rd_last_d = (rd_ptr_q == desc_end);
                        rd_ptr_d  = rd_ptr_q + ptr_t'(1);
                    end
                end
            end
            DISCARD: begin
                rd_ptr_d   = desc_end + ptr_t'(1);
                desc_rd_d  = desc_rd_q + dptr_t'(1);
                drop_cnt_d = sat_inc(drop_cnt_q);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            commit_ptr_q <= '0;
            desc_wr_q    <= '0;
            desc_rd_q    <= '0;
            ovf_drop_q   <= 1'b0;
            ovf_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            desc_wr_q    <= desc_wr_d;
            desc_rd_q    <= desc_rd_d;
            ovf_drop_q   <= ovf_drop_d;
            ovf_cnt_q    <= ovf_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // NOTE: storage arrays have no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (buf_we)    buf_mem[wr_ptr_q[ADDR_W-1:0]]   <= wr_data;
        if (desc_push) desc_mem[desc_wr_q[DESC_W-1:0]] <= wr_ptr_q;
    end

endmodule

// File: tb/tb_pkt_store_fwd_fifo.sv
// Randomized bench for pkt_store_fwd_fifo against a packet-level queue model.
module tb_pkt_store_fwd_fifo;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int DESC_W   = 2;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int MAX_PKTS = 1 << DESC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid, wr_last, act_valid, act_drop, act_ready;
    logic              rd_valid, rd_last, rd_ready;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [DESC_W:0]   pkt_count;
    logic [15:0]       ovf_cnt, drop_cnt;

    always #5 clk = ~clk;

    pkt_store_fwd_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DESC_W(DESC_W)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .act_valid(act_valid), .act_drop(act_drop), .act_ready(act_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
        .pkt_count(pkt_count), .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: committed packets as a beat queue plus a length queue.
    logic [DATA_W-1:0] buf_q[$];
    int                len_q[$];
    logic [DATA_W-1:0] cur_q[$];
    logic [DATA_W:0]   send_q[$];
    logic [DATA_W:0]   wq[$];
    bit                drop_plan[$];
    bit                dropping, disc_hold, act_en, rand_wr;
    int                hold_beats, exp_ovf, exp_drop;
    int                wr_pct = 100, rd_pct = 100, act_pct = 100, drop_pct = 0, rd_stall = 0;
    int                wr_total, wr_target;

    function automatic int npkts();
        return len_q.size() + int'(send_q.size() > 0) + int'(disc_hold);
    endfunction

    function automatic int occ();
        return buf_q.size() + cur_q.size() + send_q.size() + hold_beats;
    endfunction

    function automatic bit busy();
        return (wq.size() > 0) || (cur_q.size() > 0) || (send_q.size() > 0) || disc_hold ||
               (act_en && len_q.size() > 0) || (rand_wr && wr_total < wr_target);
    endfunction

    task automatic model_write(input logic [DATA_W:0] b);
        bit last;
        last = b[DATA_W];
        if (dropping) begin
            if (last) begin dropping = 1'b0; exp_ovf++; end
        end else if (occ() == DEPTH || (last && npkts() == MAX_PKTS)) begin
            cur_q.delete();
            if (last) exp_ovf++;
            else      dropping = 1'b1;
        end else begin
            cur_q.push_back(b[DATA_W-1:0]);
            if (last) begin
                foreach (cur_q[i]) buf_q.push_back(cur_q[i]);
                len_q.push_back(cur_q.size());
                cur_q.delete();
            end
        end
    endtask

    task automatic push_pkt(input int n, input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] step);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + DATA_W'(i) * step;
            wq.push_back({(i == n - 1), d});
        end
    endtask

    // One clock: observe at the falling edge, then drive for the next rising edge.
    task automatic cycle();
        logic [DATA_W:0]   b;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] x;
        int                len, n;
        bit                dec;
        @(negedge clk);
        check("pkt_count", 32'(pkt_count), npkts());
        check("rd_valid", 32'(rd_valid), 32'(send_q.size() > 0));
        if (rd_valid && send_q.size() > 0) check("rd_beat", {rd_last, rd_data}, 32'(send_q[0]));
        if (act_ready)
            check("act_ready_ok", 32'(len_q.size() > 0 && send_q.size() == 0 && !disc_hold), 1);

        if (rand_wr && wq.size() == 0 && wr_total < wr_target) begin
            len = $urandom_range(6, 1);
            if (occ() + len <= DEPTH && npkts() < MAX_PKTS) begin
                for (int i = 0; i < len; i++) begin
                    d = DATA_W'($urandom);
                    wq.push_back({(i == len - 1), d});
                end
                wr_total += len;
            end
        end
        wr_valid = 1'b0;
        wr_data  = DATA_W'($urandom);
        wr_last  = 1'($urandom);
        if (wq.size() > 0 && int'($urandom_range(99)) < wr_pct) begin
            b = wq.pop_front();
            wr_valid = 1'b1;
            wr_data  = b[DATA_W-1:0];
            wr_last  = b[DATA_W];
            model_write(b);
        end
        if (disc_hold) begin
            exp_drop++;
            disc_hold  = 1'b0;
            hold_beats = 0;
        end

        if (rd_stall > 0 && rd_valid) begin
            rd_ready = 1'b0;
            rd_stall--;
        end else begin
            rd_ready = int'($urandom_range(99)) < rd_pct;
        end
        if (rd_valid && rd_ready && send_q.size() > 0) void'(send_q.pop_front());

        act_valid = act_en && (int'($urandom_range(99)) < act_pct);
        dec = (drop_plan.size() > 0) ? drop_plan[0] : (int'($urandom_range(99)) < drop_pct);
        act_drop = act_valid ? dec : 1'($urandom);
        if (act_valid && act_ready) begin
            if (len_q.size() == 0) begin
                check("act_without_pkt", 1, 0);
            end else begin
                if (drop_plan.size() > 0) void'(drop_plan.pop_front());
                n = len_q.pop_front();
                if (dec) begin
                    for (int i = 0; i < n; i++) void'(buf_q.pop_front());
                    disc_hold  = 1'b1;
                    hold_beats = n;
                end else begin
                    for (int i = 0; i < n; i++) begin
                        x = buf_q.pop_front();
                        send_q.push_back({(i == n - 1), x});
                    end
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 32'(!busy()), 1);
        repeat (2) cycle();
    endtask

    task automatic model_reset();
        buf_q.delete(); len_q.delete(); cur_q.delete(); send_q.delete(); wq.delete();
        drop_plan.delete();
        dropping = 1'b0; disc_hold = 1'b0; hold_beats = 0; exp_ovf = 0; exp_drop = 0;
        rand_wr = 1'b0; rd_stall = 0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        act_valid = 1'b0; act_drop = 1'b0; rd_ready = 1'b0;
        model_reset();
        act_en = 1'b0;
        #12;
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_last", 32'(rd_last), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_act_ready", 32'(act_ready), 0);
        check("rst_pkt_count", 32'(pkt_count), 0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Plain forward of a 4-beat packet.
        act_en = 1'b1;
        drop_plan.push_back(1'b0);
        push_pkt(4, 8'h11, 8'h11);
        drain(100);

        // Drop A, forward B.
        drop_plan.push_back(1'b1);
        drop_plan.push_back(1'b0);
        push_pkt(3, 8'hA1, 8'h01);
        push_pkt(2, 8'hB1, 8'h01);
        drain(100);
        check("drop_cnt_after_a", 32'(drop_cnt), 1);

        // Backpressure: hold the first beat for 5 cycles.
        rd_stall = 5;
        push_pkt(4, 8'h51, 8'h01);
        drain(100);

        // Overflow of a 10-beat packet behind an unread 10-beat packet.
        act_en = 1'b0;
        push_pkt(10, 8'h01, 8'h01);
        drain(50);
        push_pkt(10, 8'h81, 8'h01);
        drain(50);
        check("ovf_cnt_second_pkt", 32'(ovf_cnt), 1);
        check("pkt_count_after_ovf", 32'(pkt_count), 1);
        act_en = 1'b1;
        drain(100);

        // Descriptor queue full on the fifth single-beat packet, then a wrapping stream.
        act_en = 1'b0;
        for (int i = 0; i < 5; i++) push_pkt(1, DATA_W'(8'hE0 + i), 8'h00);
        drain(50);
        check("ovf_cnt_desc_full", 32'(ovf_cnt), 2);
        check("pkt_count_desc_full", 32'(pkt_count), MAX_PKTS);
        act_en = 1'b1; drop_pct = 0; rd_pct = 70; act_pct = 60; wr_pct = 80;
        wr_total = 0; wr_target = 3 * DEPTH; rand_wr = 1'b1;
        drain(3000);
        rand_wr = 1'b0;
        check("ovf_cnt_after_stream", 32'(ovf_cnt), 2);

        // Mixed random traffic with drops and backpressure.
        drop_pct = 30; rd_pct = 50; act_pct = 40; wr_pct = 70;
        wr_total = 0; wr_target = 300; rand_wr = 1'b1;
        drain(8000);
        rand_wr = 1'b0;
        check("ovf_cnt_random", 32'(ovf_cnt), exp_ovf);
        check("drop_cnt_random", 32'(drop_cnt), exp_drop);

        // Asynchronous reset in the middle of SEND.
        drop_pct = 0; rd_pct = 40; act_pct = 100; wr_pct = 100;
        push_pkt(6, 8'h61, 8'h01);
        n = 0;
        while (send_q.size() == 0 && n < 60) begin
            cycle();
            n++;
        end
        check("reached_send", 32'(send_q.size() > 0), 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_rd_valid", 32'(rd_valid), 0);
        check("arst_pkt_count", 32'(pkt_count), 0);
        check("arst_act_ready", 32'(act_ready), 0);
        check("arst_rd_data", 32'(rd_data), 0);
        model_reset();
        wr_valid = 1'b0; act_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_pct = 100;
        push_pkt(3, 8'hC1, 8'h01);
        drain(100);
        check("ovf_cnt_post_rst", 32'(ovf_cnt), 0);
        check("drop_cnt_post_rst", 32'(drop_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule

// File: doc/pkt_store_fwd_fifo.md
PKT_STORE_FWD_FIFO -- requirements
Module: pkt_store_fwd_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of the data bus in bits.
REQ-002 Parameter ADDR_W, default 11; the data buffer depth SHALL be DEPTH = 2**ADDR_W entries.
REQ-003 Parameter DESC_W, default 4; the descriptor queue SHALL hold MAX_PKTS = 2**DESC_W complete packets.
REQ-004 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wr_valid  in  1  input beat valid; there is no input backpressure.
REQ-007 wr_data  in  DATA_W  input beat.
REQ-008 wr_last  in  1  final beat of the packet.
REQ-009 act_valid  in  1  forwarding decision valid for the oldest committed packet.
REQ-010 act_drop  in  1  1 = discard the packet, 0 = forward it.
REQ-011 act_ready  out  1  decision accepted; high only in state WAIT_ACT.
REQ-012 rd_valid  out  1  output beat valid.
REQ-013 rd_data  out  DATA_W  output beat.
REQ-014 rd_last  out  1  final output beat of the packet.
REQ-015 rd_ready  in  1  downstream accepts the beat.
REQ-016 pkt_count  out  DESC_W+1  number of committed packets not yet released.
REQ-017 ovf_cnt  out  16  count of packets discarded on overflow, saturating at 16'hFFFF.
REQ-018 drop_cnt  out  16  count of packets discarded by action, saturating at 16'hFFFF.

Function
REQ-019 Write and read pointers SHALL be ADDR_W+1 bits wide, with the buffer indexed by the low ADDR_W bits.
- Occupancy = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Pointers SHALL wrap naturally.
REQ-020 Each beat with wr_valid=1 SHALL be written at wr_ptr, and wr_ptr SHALL increment.
- A beat with wr_last=1 SHALL commit the packet: commit_ptr <= wr_ptr+1, and the end address is pushed to the descriptor queue.
REQ-021 Overflow discard applies to the whole in-flight packet.
- Trigger: a beat arrives while occupancy == DEPTH, or a wr_last beat arrives while the descriptor queue is full.
- wr_ptr SHALL rewind to commit_ptr.
- All further beats up to and including wr_last SHALL be ignored.
- ovf_cnt SHALL increment once, on that packet's wr_last cycle.
REQ-022 A single-beat packet (first beat carries wr_last=1) SHALL be supported.
REQ-023 Output FSM states and transitions:
- IDLE: to WAIT_ACT when pkt_count > 0.
- WAIT_ACT: on act_valid & act_ready, go to DISCARD if act_drop=1, else to SEND.
- SEND: drives packet beats; to IDLE after the rd_last beat handshakes.
- DISCARD: to IDLE after one cycle.
REQ-024 Decisions arriving when act_ready=0 SHALL be ignored; act_drop is sampled only at the handshake.
REQ-025 SEND latency: the first beat SHALL appear with rd_valid=1 on the cycle after the action handshake.
- Each subsequent beat SHALL appear on the cycle after the previous rd_valid & rd_ready handshake.
REQ-026 While rd_valid=1 and rd_ready=0, rd_data, rd_last and rd_valid SHALL hold stable.
REQ-027 DISCARD SHALL set rd_ptr to the descriptor end address + 1 in one cycle, pop the descriptor, and increment drop_cnt.
- rd_valid SHALL stay 0 throughout.
REQ-028 pkt_count update rules:
- +1 on commit.
- -1 on the rd_last handshake or on DISCARD.
- Unchanged when both occur in the same cycle.
REQ-029 Buffer space freed by a read or discard SHALL be usable by a write from the next cycle; a write and a read in the same cycle are both legal.
REQ-030 An in-flight, uncommitted packet SHALL never be visible to the output FSM.

Reset
REQ-031 While rst=1, regardless of clock:
- wr_ptr, rd_ptr, commit_ptr and descriptor pointers SHALL be 0.
- State SHALL be IDLE, with no discard in progress.
- pkt_count, ovf_cnt and drop_cnt SHALL be 0.
- rd_valid, rd_last and act_ready SHALL be 0.
- rd_data SHALL be 0.
REQ-032 Reset asserted mid-packet or mid-SEND SHALL discard all buffered data; no partial beat SHALL appear after deassertion.
REQ-033 Buffer contents need not be cleared.

Verification
REQ-034 Forward:
- Stimulus: 4-beat packet 0x11,0x22,0x33,0x44; act_valid=1, act_drop=0; rd_ready=1.
- Response: rd_data 0x11..0x44 on 4 consecutive cycles starting 1 cycle after the handshake; rd_last only with 0x44; pkt_count goes 1 -> 0.
REQ-035 Action drop:
- Stimulus: packets A (3 beats) and B (2 beats); act_drop=1 then 0.
- Response: only B's beats appear; drop_cnt=1.
REQ-036 Backpressure:
- Stimulus: rd_ready=0 for 5 cycles during SEND.
- Response: the same beat is held stable; no beat is lost or duplicated.
REQ-037 Overflow, ADDR_W=4:
- Stimulus: 10-beat packet committed and unread, then a 10-beat packet arrives.
- Response: the second packet is discarded; ovf_cnt=1; pkt_count=1; the first packet is forwarded intact afterward.
REQ-038 Wrap and descriptor full:
- Stimulus: with DESC_W=2, write five single-beat packets; then stream 3*DEPTH beats of traffic while forwarding.
- Response: the fifth packet is discarded (ovf_cnt=1); all later data is forwarded in order across the pointer wrap.
REQ-039 Async reset:
- Stimulus: assert rst mid-SEND, between clock edges.
- Response: rd_valid=0 and pkt_count=0 immediately; after release, a new packet is forwarded correctly.
